// File: rtl/mips_defines_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, functs, ALU ops, control word.
package mips_defines_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam logic [4:0]  REG_RA = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_imm;
    logic    imm_zext;
    logic    reg_write;
    logic    reg_dst_rd;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch_eq;
    logic    branch_ne;
    logic    jump;
    logic    link;
    logic    jump_reg;
  } ctrl_t;

endpackage

// File: rtl/mips_processor_if.sv
// Instruction-ROM and data-memory bus of the core; master is the core, slave the memories.
interface mips_processor_if;
  logic [31:0] instruction;
  logic [31:0] data;
  logic [31:0] rg_pc;
  logic [31:0] data_address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;

  modport master (
    input  instruction, data,
    output rg_pc, data_address, write_data, mem_read, mem_write
  );

  modport slave (
    output instruction, data,
    input  rg_pc, data_address, write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mips_register_file.sv
// 32x32 register file: two combinational read ports, one write port, r0 hardwired to zero.
module mips_register_file
  import mips_defines_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr_a,
  input  logic [4:0]      i_raddr_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b
);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mips_processor.sv
// Single-cycle 32-bit MIPS core: PC, decode, ALU, next-PC and write-back muxes.
// Define MIPS_DUMP_EN to print PC and registers on a rising edge of dump_all.
module mips_processor
  import mips_defines_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            dump_all,
  mips_processor_if.master bus
);

  logic [31:0] r_pc;
  ctrl_t       w_ctrl;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_waddr;
  logic [15:0] w_imm16;
  logic [25:0] w_target;
  logic [31:0] w_imm_sext, w_imm, w_a, w_b, w_rt_val, w_alu, w_wdata;
  logic [31:0] w_pc4, w_br_target, w_next_pc;
  logic        w_taken, w_rf_we;

  assign w_op       = bus.instruction[31:26];
  assign w_rs       = bus.instruction[25:21];
  assign w_rt       = bus.instruction[20:16];
  assign w_rd       = bus.instruction[15:11];
  assign w_shamt    = bus.instruction[10:6];
  assign w_funct    = bus.instruction[5:0];
  assign w_imm16    = bus.instruction[15:0];
  assign w_target   = bus.instruction[25:0];
  assign w_imm_sext = {{16{w_imm16[15]}}, w_imm16};
  assign w_imm      = w_ctrl.imm_zext ? {16'h0000, w_imm16} : w_imm_sext;

  // Control decode; anything unrecognised leaves the all-zero control word (NOP)
  always_comb begin
    w_ctrl        = '0;
    w_ctrl.alu_op = ALU_ADD;
    case (w_op)
      OP_RTYPE: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst_rd = 1'b1;
        case (w_funct)
          FN_ADD, FN_ADDU: w_ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: w_ctrl.alu_op = ALU_SUB;
          FN_AND:          w_ctrl.alu_op = ALU_AND;
          FN_OR:           w_ctrl.alu_op = ALU_OR;
          FN_XOR:          w_ctrl.alu_op = ALU_XOR;
          FN_NOR:          w_ctrl.alu_op = ALU_NOR;
          FN_SLT:          w_ctrl.alu_op = ALU_SLT;
          FN_SLTU:         w_ctrl.alu_op = ALU_SLTU;
          FN_SLL:          w_ctrl.alu_op = ALU_SLL;
          FN_SRL:          w_ctrl.alu_op = ALU_SRL;
          FN_SRA:          w_ctrl.alu_op = ALU_SRA;
          FN_JR: begin
            w_ctrl.reg_write = 1'b0;
            w_ctrl.jump_reg  = 1'b1;
          end
          default:         w_ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
      end
      OP_SLTI: begin
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.alu_op      = ALU_SLT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.imm_zext    = 1'b1;
        w_ctrl.alu_op      = (w_op == OP_ANDI) ? ALU_AND :
                             (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.alu_op      = ALU_LUI;
      end
      OP_LW: begin
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.mem_read    = 1'b1;
        w_ctrl.mem_to_reg  = 1'b1;
      end
      OP_SW: begin
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.mem_write   = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl.branch_eq = 1'b1;
        w_ctrl.alu_op    = ALU_SUB;
      end
      OP_BNE: begin
        w_ctrl.branch_ne = 1'b1;
        w_ctrl.alu_op    = ALU_SUB;
      end
      OP_J:   w_ctrl.jump = 1'b1;
      OP_JAL: begin
        w_ctrl.jump      = 1'b1;
        w_ctrl.link      = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  mips_register_file u_rf (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_rf_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_a),
    .o_rdata_b (w_rt_val)
  );

  assign w_b = w_ctrl.alu_src_imm ? w_imm : w_rt_val;

  always_comb begin
    w_alu = '0;
    case (w_ctrl.alu_op)
      ALU_ADD:  w_alu = w_a + w_b;
      ALU_SUB:  w_alu = w_a - w_b;
      ALU_AND:  w_alu = w_a & w_b;
      ALU_OR:   w_alu = w_a | w_b;
      ALU_XOR:  w_alu = w_a ^ w_b;
      ALU_NOR:  w_alu = ~(w_a | w_b);
      ALU_SLT:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      ALU_SLTU: w_alu = {31'd0, w_a < w_b};
      ALU_SLL:  w_alu = w_b << w_shamt;
      ALU_SRL:  w_alu = w_b >> w_shamt;
      ALU_SRA:  w_alu = 32'($signed(w_b) >>> w_shamt);
      ALU_LUI:  w_alu = {w_b[15:0], 16'h0000};
      default:  w_alu = w_a + w_b;
    endcase
  end

  // Write-back: jal links r31 with PC+4, loads take memory data
  assign w_waddr = w_ctrl.link ? REG_RA : (w_ctrl.reg_dst_rd ? w_rd : w_rt);
  assign w_wdata = w_ctrl.link ? w_pc4 : (w_ctrl.mem_to_reg ? bus.data : w_alu);
  assign w_rf_we = w_ctrl.reg_write & ~hold;

  assign w_pc4       = r_pc + 32'd4;
  assign w_br_target = w_pc4 + {w_imm_sext[29:0], 2'b00};
  assign w_taken     = (w_ctrl.branch_eq & (w_a == w_rt_val)) |
                       (w_ctrl.branch_ne & (w_a != w_rt_val));
  assign w_next_pc   = w_ctrl.jump_reg ? w_a :
                       w_ctrl.jump     ? {w_pc4[31:28], w_target, 2'b00} :
                       w_taken         ? w_br_target : w_pc4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_pc <= '0;
    else if (!hold) r_pc <= w_next_pc;
  end

  assign bus.rg_pc        = r_pc;
  assign bus.data_address = w_alu;
  assign bus.write_data   = w_rt_val;
  assign bus.mem_read     = w_ctrl.mem_read  & ~hold & ~reset;
  assign bus.mem_write    = w_ctrl.mem_write & ~hold & ~reset;

`ifdef MIPS_DUMP_EN
  always @(posedge dump_all) begin
    $display("pc %08h", r_pc);
    for (int i = 0; i < int'(NREGS); i++) $display("%0d %08h", i, u_rf.r_regs[i]);
  end
`else
  logic w_unused_dump;
  assign w_unused_dump = dump_all;
`endif

endmodule

// File: tb/tb_mips_processor.sv
// Directed bench for mips_processor: drives one instruction per cycle and scoreboards bus outputs.
module tb_mips_processor;

  logic clk = 1'b0;
  logic reset, hold, dump_all;

  mips_processor_if bus ();

  mips_processor dut (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .dump_all (dump_all),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write at the rising edge
  logic [31:0] dmem [64];
  always @(posedge clk) if (bus.mem_write) dmem[bus.data_address[7:2]] <= bus.write_data;
  assign bus.data = dmem[bus.data_address[7:2]];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mr;
    logic        mw;
    logic [1:0]  mask;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] pc_model;
  logic [31:0] ra;

  localparam logic [5:0] ADD = 6'h20, SUB = 6'h22, SLT = 6'h2A, SLTU = 6'h2B, JR = 6'h08;
  localparam logic [5:0] SLL = 6'h00, SRL = 6'h02, SRA = 6'h03, NOR = 6'h27;
  localparam logic [5:0] ADDI = 6'h08, ADDIU = 6'h09, SLTI = 6'h0A, ANDI = 6'h0C, ORI = 6'h0D;
  localparam logic [5:0] XORI = 6'h0E, LUI = 6'h0F, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04;
  localparam logic [5:0] BNE = 6'h05, J = 6'h02, JAL = 6'h03;

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] t);
    return {op, t};
  endfunction

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wd,
                          input logic mr, input logic mw, input logic [1:0] mask, input string tag);
    exp_t e;
    e.pc = pc; e.addr = addr; e.wd = wd; e.mr = mr; e.mw = mw; e.mask = mask; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    n_vec++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL scoreboard_empty got 0 entries required 1");
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    assert (bus.rg_pc === e.pc) else begin
      n_err++; $error("FAIL %s.pc got %08h required %08h", e.tag, bus.rg_pc, e.pc);
    end
    n_vec++;
    assert (bus.mem_read === e.mr) else begin
      n_err++; $error("FAIL %s.mem_read got %b required %b", e.tag, bus.mem_read, e.mr);
    end
    n_vec++;
    assert (bus.mem_write === e.mw) else begin
      n_err++; $error("FAIL %s.mem_write got %b required %b", e.tag, bus.mem_write, e.mw);
    end
    if (e.mask[0]) begin
      n_vec++;
      assert (bus.data_address === e.addr) else begin
        n_err++; $error("FAIL %s.data_address got %08h required %08h", e.tag, bus.data_address, e.addr);
      end
    end
    if (e.mask[1]) begin
      n_vec++;
      assert (bus.write_data === e.wd) else begin
        n_err++; $error("FAIL %s.write_data got %08h required %08h", e.tag, bus.write_data, e.wd);
      end
    end
  endtask

  // One instruction: drive at the falling edge, check after settling, retire at the rising edge
  task automatic step(input logic [31:0] ins, input logic h, input logic [31:0] nxt,
                      input logic [31:0] addr, input logic [31:0] wd, input logic mr,
                      input logic mw, input logic [1:0] mask, input string tag);
    @(negedge clk);
    bus.instruction = ins;
    hold = h;
    push_exp(pc_model, addr, wd, mr, mw, mask, tag);
    #1 check();
    @(posedge clk);
    pc_model = nxt;
  endtask

  // Read a register through the ALU: add r0,r0,rX puts rX on data_address and write_data
  task automatic probe(input logic [4:0] r, input logic [31:0] val, input string tag);
    step(enc_r(5'd0, r, 5'd0, 5'd0, ADD), 1'b0, pc_model + 32'd4, val, val, 1'b0, 1'b0, 2'b11, tag);
  endtask

  initial begin
    reset = 1'b1;
    hold = 1'b0;
    dump_all = 1'b0;
    bus.instruction = enc_i(SW, 5'd0, 5'd1, 16'd8);
    pc_model = 32'd0;
    push_exp(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, "reset");
    #3 check();
    @(negedge clk);
    bus.instruction = 32'd0;
    #1 reset = 1'b0;
    @(posedge clk);
    pc_model = 32'd4;

    step(32'd0, 1'b0, pc_model + 32'd4, 0, 0, 1'b0, 1'b0, 2'b00, "pc_step4");
    step(32'd0, 1'b0, pc_model + 32'd4, 0, 0, 1'b0, 1'b0, 2'b00, "pc_step8");

    step(enc_i(ADDI, 5'd0, 5'd1, 16'd5),    1'b0, pc_model + 32'd4, 32'd5, 0, 1'b0, 1'b0, 2'b01, "addi_r1");
    step(enc_i(ADDI, 5'd0, 5'd2, 16'hFFFD), 1'b0, pc_model + 32'd4, 32'hFFFFFFFD, 0, 1'b0, 1'b0, 2'b01, "addi_r2");
    step(enc_r(5'd1, 5'd2, 5'd3, 5'd0, ADD),  1'b0, pc_model + 32'd4, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b0, 2'b11, "add_r3");
    step(enc_r(5'd2, 5'd1, 5'd4, 5'd0, SUB),  1'b0, pc_model + 32'd4, 32'hFFFFFFF8, 32'd5, 1'b0, 1'b0, 2'b11, "sub_r4");
    step(enc_r(5'd2, 5'd1, 5'd5, 5'd0, SLT),  1'b0, pc_model + 32'd4, 32'd1, 0, 1'b0, 1'b0, 2'b01, "slt_r5");
    step(enc_r(5'd2, 5'd1, 5'd6, 5'd0, SLTU), 1'b0, pc_model + 32'd4, 32'd0, 0, 1'b0, 1'b0, 2'b01, "sltu_r6");
    probe(5'd3, 32'd2, "probe_r3");
    probe(5'd4, 32'hFFFFFFF8, "probe_r4");
    probe(5'd5, 32'd1, "probe_r5");
    probe(5'd6, 32'd0, "probe_r6");

    step(enc_i(SW, 5'd0, 5'd1, 16'd8), 1'b0, pc_model + 32'd4, 32'd8, 32'd5, 1'b0, 1'b1, 2'b11, "sw_r1");
    step(enc_i(LW, 5'd0, 5'd7, 16'd8), 1'b0, pc_model + 32'd4, 32'd8, 0, 1'b1, 1'b0, 2'b01, "lw_r7");
    probe(5'd7, 32'd5, "probe_r7");

    step(enc_i(ORI,  5'd0, 5'd11, 16'hF0F0), 1'b0, pc_model + 32'd4, 32'h0000F0F0, 0, 1'b0, 1'b0, 2'b01, "ori");
    step(enc_i(ANDI, 5'd2, 5'd12, 16'h8000), 1'b0, pc_model + 32'd4, 32'h00008000, 0, 1'b0, 1'b0, 2'b01, "andi_zext");
    step(enc_i(XORI, 5'd1, 5'd18, 16'hFFFF), 1'b0, pc_model + 32'd4, 32'h0000FFFA, 0, 1'b0, 1'b0, 2'b01, "xori_zext");
    step(enc_i(LUI,  5'd0, 5'd13, 16'h1234), 1'b0, pc_model + 32'd4, 32'h12340000, 0, 1'b0, 1'b0, 2'b01, "lui");
    step(enc_i(SLTI, 5'd2, 5'd19, 16'hFFFE), 1'b0, pc_model + 32'd4, 32'd1, 0, 1'b0, 1'b0, 2'b01, "slti");
    step(enc_i(ADDIU, 5'd2, 5'd21, 16'd1),   1'b0, pc_model + 32'd4, 32'hFFFFFFFE, 0, 1'b0, 1'b0, 2'b01, "addiu");
    step(enc_r(5'd0, 5'd1, 5'd14, 5'd4,  SLL), 1'b0, pc_model + 32'd4, 32'h00000050, 0, 1'b0, 1'b0, 2'b01, "sll");
    step(enc_r(5'd0, 5'd2, 5'd15, 5'd1,  SRA), 1'b0, pc_model + 32'd4, 32'hFFFFFFFE, 0, 1'b0, 1'b0, 2'b01, "sra");
    step(enc_r(5'd0, 5'd2, 5'd16, 5'd28, SRL), 1'b0, pc_model + 32'd4, 32'h0000000F, 0, 1'b0, 1'b0, 2'b01, "srl");
    step(enc_r(5'd0, 5'd0, 5'd17, 5'd0,  NOR), 1'b0, pc_model + 32'd4, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 2'b01, "nor");
    probe(5'd13, 32'h12340000, "probe_r13");

    step(enc_i(BEQ, 5'd1, 5'd1, 16'd2), 1'b0, pc_model + 32'd12, 0, 32'd5, 1'b0, 1'b0, 2'b10, "beq_taken");
    step(enc_i(BNE, 5'd1, 5'd1, 16'd2), 1'b0, pc_model + 32'd4, 0, 32'd5, 1'b0, 1'b0, 2'b10, "bne_equal");
    step(enc_i(BNE, 5'd1, 5'd2, 16'd1), 1'b0, pc_model + 32'd8, 0, 0, 1'b0, 1'b0, 2'b00, "bne_taken");
    step(enc_i(BEQ, 5'd1, 5'd2, 16'd3), 1'b0, pc_model + 32'd4, 0, 0, 1'b0, 1'b0, 2'b00, "beq_not");
    step(enc_i(BEQ, 5'd0, 5'd0, 16'hFFFF), 1'b0, pc_model, 0, 0, 1'b0, 1'b0, 2'b00, "beq_back");
    ra = pc_model + 32'd4;
    step(enc_j(JAL, 26'h40), 1'b0, 32'h100, 0, 0, 1'b0, 1'b0, 2'b00, "jal");
    probe(5'd31, ra, "probe_r31");
    step(enc_r(5'd31, 5'd0, 5'd0, 5'd0, JR), 1'b0, ra, 0, 0, 1'b0, 1'b0, 2'b00, "jr");
    step(enc_j(J, 26'h10), 1'b0, 32'h40, 0, 0, 1'b0, 1'b0, 2'b00, "j");
    step(32'd0, 1'b0, pc_model + 32'd4, 0, 0, 1'b0, 1'b0, 2'b00, "after_j");

    step(enc_i(SW,   5'd0, 5'd1, 16'd12), 1'b1, pc_model, 32'd12, 32'd5, 1'b0, 1'b0, 2'b11, "hold_sw");
    step(enc_i(ADDI, 5'd0, 5'd1, 16'd99), 1'b1, pc_model, 32'd99, 0, 1'b0, 1'b0, 2'b01, "hold_addi");
    step(enc_i(LW,   5'd0, 5'd7, 16'd0),  1'b1, pc_model, 0, 0, 1'b0, 1'b0, 2'b00, "hold_lw");
    probe(5'd1, 32'd5, "hold_r1");

    step(enc_i(ADDI, 5'd0, 5'd0, 16'd7), 1'b0, pc_model + 32'd4, 32'd7, 0, 1'b0, 1'b0, 2'b01, "addi_r0");
    probe(5'd0, 32'd0, "probe_r0");

    step({6'h3F, 5'd0, 5'd1, 16'd1}, 1'b0, pc_model + 32'd4, 0, 0, 1'b0, 1'b0, 2'b00, "bad_opcode");
    step(enc_r(5'd0, 5'd0, 5'd1, 5'd0, 6'h3F), 1'b0, pc_model + 32'd4, 0, 0, 1'b0, 1'b0, 2'b00, "bad_funct");
    probe(5'd1, 32'd5, "nop_r1");

    // Asynchronous reset mid-program
    @(negedge clk);
    bus.instruction = enc_i(SW, 5'd0, 5'd1, 16'd8);
    #2 reset = 1'b1;
    push_exp(32'd0, 0, 0, 1'b0, 1'b0, 2'b00, "mid_reset");
    #1 check();
    @(negedge clk);
    bus.instruction = 32'd0;
    #1 reset = 1'b0;
    @(posedge clk);
    pc_model = 32'd4;
    probe(5'd1, 32'd0, "reset_r1");
    probe(5'd31, 32'd0, "reset_r31");

    @(negedge clk);
    dump_all = 1'b1;
    @(negedge clk);
    dump_all = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_processor.md
# mips_processor

Single-cycle 32-bit MIPS core: fetches one instruction per clock from an external combinational instruction ROM addressed by the PC, executes it, and accesses an external data memory. It contains the PC, a 32×32 register file, the ALU, control decode and the next-PC/write-back muxes. It sits between the instruction ROM (word-addressed by `rg_pc[31:2]`) and the data memory in the system top.

## Interface
- No parameters; widths are fixed at 32 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears the PC and every register.
- `hold` input 1: when 1, the core freezes; there is no PC, register or memory write.
- `dump_all` input 1: test hook that prints the register file (see Configuration).
- `instruction` input 32: the instruction at `rg_pc`; combinational from the ROM.
- `data` input 32: data-memory read data; combinational for `data_address`.
- `rg_pc` output 32: program counter; a registered output.
- `data_address` output 32: ALU result; used as the byte address for lw/sw.
- `write_data` output 32: rt register value; the store data.
- `mem_read` output 1: 1 during lw.
- `mem_write` output 1: 1 during sw; the data memory writes on the rising edge.

## Operation
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi, addiu, andi, ori, xori, slti, lui, lw, sw, beq, bne.
  - J-type: j, jal.
- Any other opcode or funct is a NOP: no register or memory write, and PC+4.
- Arithmetic wraps modulo 2^32. Overflow is ignored and there are no exceptions.
- slt compares signed; sltu compares unsigned.
- Immediate extension:
  - addi, addiu, slti, lw, sw, beq, bne: sign-extended.
  - andi, ori, xori: zero-extended.
  - lui: imm<<16.
- Shifts use the shamt field, bits [10:6].
- Write-back destination:
  - R-type writes rd.
  - I-type writes rt.
  - jal writes r31 with PC+4.
  - lw writes `data`.
- Register r0 reads as 0, and writes to it are discarded.
- Register reads are combinational. A register written this cycle becomes visible the next cycle.
- Next PC:
  - Default: PC+4.
  - Taken beq/bne: PC+4+(sext(imm)<<2).
  - j/jal: {PC+4[31:28], target, 2'b00}.
  - jr: rs.
- Memory outputs:
  - `data_address` is always the ALU result.
  - `write_data` is always the rt value.
  - `mem_read` and `mem_write` are decoded, and forced to 0 while `hold` or `reset` is asserted.

## Timing
- One instruction per clock; every instruction has a latency of 1 cycle.
- The PC and register file update on the rising edge of `clk` when `hold`=0.
- Reset (asynchronous, active-high):
  - Immediately sets `rg_pc`=0 and all registers to 0.
  - `mem_write`=0 and `mem_read`=0 while asserted.
  - Deassertion mid-program restarts execution at address 0.
- Hold:
  - `hold`=1 keeps `rg_pc` and the registers unchanged indefinitely.
  - Deasserting `hold` resumes with the same instruction.
- Reset has priority over `hold`.
- A store followed by a load to the same address returns the stored value, since the memory write completes at the edge.

## Configuration
- `MIPS_DUMP_EN` defined:
  - A rising edge on `dump_all` prints `rg_pc` and all 32 registers, one `$display` per register, as decimal index followed by hex value.
- Undefined:
  - `dump_all` is ignored and no simulation-only code is compiled.

## Structure
- Shared package `mips_defines_pkg` holds:
  - opcode and funct constants;
  - ALU-operation encoding;
  - register index constant `REG_RA`=31.
- Sub-module `mips_register_file`:
  - two combinational read ports and one write port;
  - asynchronous reset;
  - r0 hardwired to 0.
- ALU, control decode and muxes stay inline in `mips_processor`.

## Test plan
- Reset: assert `reset` for 11 time units → `rg_pc`=0 and `mem_write`=0; PC steps 0, 4, 8 on successive edges afterwards.
- Arithmetic:
  - addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 → r3=2.
  - sub r4,r2,r1 → r4=0xFFFFFFF8.
  - slt r5,r2,r1 → r5=1.
  - sltu r6,r2,r1 → r6=0.
- Memory:
  - sw r1,8(r0) → `mem_write`=1, `data_address`=8, `write_data`=5 for one cycle.
  - Then lw r7,8(r0) → r7=5.
- Control flow:
  - beq r1,r1,+2 at PC=0x10 → next PC 0x1C.
  - bne with equal operands → 0x14.
  - jal 0x40 → PC 0x100, r31=PC+4.
  - jr r31 returns.
- Hold and r0:
  - `hold`=1 for 3 cycles → `rg_pc` is constant and there are no register or memory writes.
  - addi r0,r0,7 → r0 reads 0.
- Dump (`MIPS_DUMP_EN`): pulse `dump_all` after the program → 32 register lines printed with the final values above.
